// File: rtl/mlx_defs.sv
// Shared definitions for the MLX90640 frame reader: camera register map,
// status bit positions and the sequencer state encoding.
package mlx_defs;

  localparam logic [15:0] REG_STATUS   = 16'h8000;
  localparam logic [15:0] REG_RAM      = 16'h0400;
  localparam int          NEW_DATA_BIT = 3;
  localparam int          SUBPAGE_BIT  = 0;
  localparam logic [7:0]  CLR_MASK     = ~(8'h01 << NEW_DATA_BIT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL_A,
    S_POLL_B,
    S_POLL_STOP,
    S_POLL_RD,
    S_POLL_EVAL,
    S_WAIT,
    S_RAM_A,
    S_RAM_B,
    S_RAM_STOP,
    S_RAM_RD,
    S_CLR_A,
    S_CLR_END,
    S_ERROR
  } state_t;

endpackage

// File: rtl/i2c_edge_detect.sv
// Two-stage history of an i2c_controller level; rise pulses for one clk
// the cycle after the level goes high.
module i2c_edge_detect (
  input  logic clk,
  input  logic not_reset,
  input  logic level,
  output logic rise
);

  logic [1:0] hist;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) hist <= 2'b00;
    else            hist <= {hist[0], level};
  end

  assign rise = (hist == 2'b01);

endmodule

// File: rtl/mlx_frame_reader.sv
// Polls the MLX90640 status register, reads one RAM subpage into the pixel
// buffer, clears the new-data flag and pulses frame_ready.
//
// state       | meaning
// S_IDLE      | stopped, waits for run and a free bus
// S_POLL_A/B  | write status register address 0x8000
// S_POLL_STOP | repeated start towards the status read
// S_POLL_RD   | read status_hi, status_lo
// S_POLL_EVAL | new data -> RAM read, else wait
// S_WAIT      | POLL_TICKS between polls
// S_RAM_A/B   | write RAM address 0x0400
// S_RAM_STOP  | repeated start towards the RAM read
// S_RAM_RD    | stream RAM_BYTES into the pixel buffer
// S_CLR_A     | write status back with new-data cleared
// S_CLR_END   | wait for bus idle, publish the frame
// S_ERROR     | nack seen, back off RETRY_TICKS
module mlx_frame_reader
  import mlx_defs::*;
#(
  parameter logic [6:0] CHIP_ADDRESS = 7'h33,
  parameter int         RAM_BYTES    = 1664,
  parameter int         POLL_TICKS   = 2400,
  parameter int         RETRY_TICKS  = 24000
) (
  input  logic        clk,
  input  logic        not_reset,
  input  logic        run,
  output logic [6:0]  address,
  output logic        read_write,
  output logic [7:0]  transmit_data,
  output logic        enable_transfer,
  input  logic        idle,
  input  logic        ack,
  input  logic        nack,
  input  logic [7:0]  received_data,
  output logic [10:0] pixel_addr,
  output logic [7:0]  pixel_data,
  output logic        pixel_we,
  output logic        frame_ready,
  output logic        subpage,
  output logic        busy,
  output logic        error
);

  localparam logic [14:0] RAM_LAST   = 15'(RAM_BYTES - 1);
  localparam logic [14:0] POLL_LAST  = 15'(POLL_TICKS - 1);
  localparam logic [14:0] RETRY_LAST = 15'(RETRY_TICKS - 1);

  state_t      state;
  logic [14:0] counter;
  logic [7:0]  status_hi;
  logic [7:0]  status_lo;
  logic        ok;
  logic        fail;
  logic        in_txn;

  i2c_edge_detect u_ack_edge  (.clk(clk), .not_reset(not_reset), .level(ack),  .rise(ok));
  i2c_edge_detect u_nack_edge (.clk(clk), .not_reset(not_reset), .level(nack), .rise(fail));

  assign address = CHIP_ADDRESS;
  assign in_txn  = !(state inside {S_IDLE, S_WAIT, S_ERROR});

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state           <= S_IDLE;
      counter         <= '0;
      status_hi       <= '0;
      status_lo       <= '0;
      read_write      <= 1'b0;
      transmit_data   <= '0;
      enable_transfer <= 1'b0;
      pixel_addr      <= '0;
      pixel_data      <= '0;
      pixel_we        <= 1'b0;
      frame_ready     <= 1'b0;
      subpage         <= 1'b0;
      busy            <= 1'b0;
      error           <= 1'b0;
    end else begin
      pixel_we    <= 1'b0;
      frame_ready <= 1'b0;
      if (fail && in_txn) begin
        enable_transfer <= 1'b0;
        error           <= 1'b1;
        counter         <= '0;
        state           <= S_ERROR;
      end else begin
        case (state)
          S_IDLE: if (run && idle) begin
            read_write      <= 1'b0;
            transmit_data   <= REG_STATUS[15:8];
            enable_transfer <= 1'b1;
            busy            <= 1'b1;
            state           <= S_POLL_A;
          end
          S_POLL_A: if (ok) begin
            transmit_data <= REG_STATUS[7:0];
            state         <= S_POLL_B;
          end
          S_POLL_B: if (ok) begin
            enable_transfer <= 1'b0;
            state           <= S_POLL_STOP;
          end
          S_POLL_STOP: begin
            read_write <= 1'b1;
            if (idle) begin
              enable_transfer <= 1'b1;
              counter         <= '0;
              state           <= S_POLL_RD;
            end
          end
          S_POLL_RD: if (ok) begin
            if (counter == 15'd0) begin
              status_hi <= received_data;
              counter   <= 15'd1;
            end else begin
              status_lo       <= received_data;
              enable_transfer <= 1'b0;
              state           <= S_POLL_EVAL;
            end
          end
          S_POLL_EVAL: if (idle) begin
            counter <= '0;
            if (status_lo[NEW_DATA_BIT]) begin
              read_write      <= 1'b0;
              transmit_data   <= REG_RAM[15:8];
              enable_transfer <= 1'b1;
              state           <= S_RAM_A;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (counter == POLL_LAST) begin
              counter <= '0;
              if (run) begin
                read_write      <= 1'b0;
                transmit_data   <= REG_STATUS[15:8];
                enable_transfer <= 1'b1;
                state           <= S_POLL_A;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              counter <= counter + 15'd1;
            end
          end
          S_RAM_A: if (ok) begin
            transmit_data <= REG_RAM[7:0];
            state         <= S_RAM_B;
          end
          S_RAM_B: if (ok) begin
            enable_transfer <= 1'b0;
            state           <= S_RAM_STOP;
          end
          S_RAM_STOP: begin
            read_write <= 1'b1;
            if (idle) begin
              enable_transfer <= 1'b1;
              counter         <= '0;
              state           <= S_RAM_RD;
            end
          end
          S_RAM_RD: if (ok) begin
            pixel_we   <= 1'b1;
            pixel_addr <= counter[10:0];
            pixel_data <= received_data;
            if (counter == RAM_LAST) begin
              enable_transfer <= 1'b0;
              counter         <= '0;
              state           <= S_CLR_A;
            end else begin
              counter <= counter + 15'd1;
            end
          end
          // enable low: waiting for the RAM read to release the bus
          S_CLR_A: begin
            if (!enable_transfer) begin
              if (idle) begin
                read_write      <= 1'b0;
                transmit_data   <= REG_STATUS[15:8];
                enable_transfer <= 1'b1;
                counter         <= '0;
              end
            end else if (ok) begin
              counter <= counter + 15'd1;
              case (counter[1:0])
                2'd0:    transmit_data <= REG_STATUS[7:0];
                2'd1:    transmit_data <= status_hi;
                2'd2:    transmit_data <= status_lo & CLR_MASK;
                default: begin
                  enable_transfer <= 1'b0;
                  state           <= S_CLR_END;
                end
              endcase
            end
          end
          S_CLR_END: if (idle) begin
            subpage     <= status_lo[SUBPAGE_BIT];
            error       <= 1'b0;
            frame_ready <= 1'b1;
            counter     <= '0;
            state       <= S_WAIT;
          end
          S_ERROR: begin
            if (counter == RETRY_LAST) begin
              counter <= '0;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              counter <= counter + 15'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlx_frame_reader.sv
// Bench for mlx_frame_reader: behavioural i2c_controller + MLX90640 model,
// pixel scoreboard fed by the model and drained by pixel_we.
module tb_mlx_frame_reader;

  localparam int RAM_BYTES   = 1664;
  localparam int POLL_TICKS  = 2400;
  localparam int RETRY_TICKS = 24000;

  logic        clk = 1'b0;
  logic        not_reset;
  logic        run;
  logic [6:0]  address;
  logic        read_write;
  logic [7:0]  transmit_data;
  logic        enable_transfer;
  logic        idle = 1'b1;
  logic        ack = 1'b0;
  logic        nack = 1'b0;
  logic [7:0]  received_data = 8'h00;
  logic [10:0] pixel_addr;
  logic [7:0]  pixel_data;
  logic        pixel_we;
  logic        frame_ready;
  logic        subpage;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  mlx_frame_reader dut (
    .clk(clk), .not_reset(not_reset), .run(run), .address(address),
    .read_write(read_write), .transmit_data(transmit_data),
    .enable_transfer(enable_transfer), .idle(idle), .ack(ack), .nack(nack),
    .received_data(received_data), .pixel_addr(pixel_addr),
    .pixel_data(pixel_data), .pixel_we(pixel_we), .frame_ready(frame_ready),
    .subpage(subpage), .busy(busy), .error(error)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- camera / i2c_controller model ----------------
  typedef struct { int len; logic [31:0] bytes; int t; } wlog_t;
  typedef enum { M_IDLE, M_GAP, M_HI, M_STOP } mst_t;

  wlog_t       wlog[$];
  logic [7:0]  status_q[$];
  logic [18:0] exp_q[$];
  logic [7:0]  stat_hi = 8'h01;
  int          fault_byte = -1;
  mst_t        m_st = M_IDLE;
  int          m_cnt, m_idx, m_t;
  logic        m_rw;
  logic [15:0] m_reg = 16'h0000;
  logic [7:0]  m_b[4];

  always @(negedge clk) begin
    if (!not_reset) begin
      m_st = M_IDLE; idle = 1'b1; ack = 1'b0; nack = 1'b0; m_reg = 16'h0000;
    end else begin
      case (m_st)
        M_IDLE: if (enable_transfer && idle) begin
          idle = 1'b0; m_rw = read_write; m_idx = 0; m_t = cyc;
          for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
          m_st = M_GAP;
        end
        M_GAP: begin
          if (!enable_transfer) begin
            m_st = M_STOP; m_cnt = 0;
          end else begin
            if (!m_rw) begin
              if (m_idx < 4) m_b[m_idx] = transmit_data;
              ack = 1'b1;
            end else if (m_reg == 16'h0400) begin
              if (m_idx == fault_byte) nack = 1'b1;
              else begin
                received_data = m_idx[7:0];
                exp_q.push_back({m_idx[10:0], m_idx[7:0]});
                ack = 1'b1;
              end
            end else begin
              if (m_idx == 0) received_data = stat_hi;
              else if (status_q.size() > 0) received_data = status_q.pop_front();
              else received_data = 8'h00;
              ack = 1'b1;
            end
            m_idx++; m_cnt = 0; m_st = M_HI;
          end
        end
        M_HI: begin
          m_cnt++;
          if (m_cnt == 2) begin
            ack = 1'b0; nack = 1'b0;
            if (enable_transfer) m_st = M_GAP;
            else begin m_st = M_STOP; m_cnt = 0; end
          end
        end
        M_STOP: begin
          m_cnt++;
          if (m_cnt == 2) begin
            idle = 1'b1;
            if (!m_rw) begin
              wlog.push_back('{m_idx, {m_b[0], m_b[1], m_b[2], m_b[3]}, m_t});
              if (m_idx >= 2) m_reg = {m_b[0], m_b[1]};
            end
            m_st = M_IDLE;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  // ---------------- pixel scoreboard ----------------
  int          pix_cnt = 0;
  logic [18:0] exp_e;
  always @(negedge clk) begin
    if (not_reset && pixel_we) begin
      pix_cnt++;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
      check("pixel", {13'd0, pixel_addr, pixel_data}, {13'd0, exp_e});
    end
  end

  function automatic int poll_count();
    int n = 0;
    foreach (wlog[i]) if (wlog[i].len == 2 && wlog[i].bytes[31:16] == 16'h8000) n++;
    return n;
  endfunction

  function automatic int last_poll_t();
    int t = -1;
    foreach (wlog[i]) if (wlog[i].len == 2 && wlog[i].bytes[31:16] == 16'h8000) t = wlog[i].t;
    return t;
  endfunction

  task automatic wait_frame(input int budget);
    int k = 0;
    while (!frame_ready && k < budget) begin @(negedge clk); k++; end
    check("frame_ready", {31'd0, frame_ready}, 32'd1);
  endtask

  task automatic wait_pix(input int base, input int n, input int budget);
    int k = 0;
    while (pix_cnt - base < n && k < budget) begin @(negedge clk); k++; end
    check("wait_pix", {31'd0, (pix_cnt - base >= n)}, 32'd1);
  endtask

  initial begin
    int pb, lg, t_err, k, gap, fr_seen;
    int pt[$];
    not_reset = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_enable", {31'd0, enable_transfer}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_we", {31'd0, pixel_we}, 0);
    check("rst_frame", {31'd0, frame_ready}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_subpage", {31'd0, subpage}, 0);
    check("rst_rw", {31'd0, read_write}, 0);
    check("rst_tx", {24'd0, transmit_data}, 0);
    check("rst_paddr", {21'd0, pixel_addr}, 0);
    check("rst_addr", {25'd0, address}, 32'h33);
    not_reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 0);

    // three empty polls, then new data on subpage 1
    status_q = '{8'h00, 8'h00, 8'h00, 8'h09}; stat_hi = 8'h01; pb = pix_cnt;
    run = 1'b1;
    wait_frame(20000);
    @(negedge clk);
    check("fr_pulse", {31'd0, frame_ready}, 0);
    check("f1_pix", pix_cnt - pb, RAM_BYTES);
    check("f1_sb", exp_q.size(), 0);
    check("f1_polls", poll_count(), 4);
    pt = {};
    foreach (wlog[i]) if (wlog[i].len == 2 && wlog[i].bytes[31:16] == 16'h8000) pt.push_back(wlog[i].t);
    for (int i = 1; i < pt.size(); i++) begin
      gap = pt[i] - pt[i-1];
      check("poll_gap_ok", {31'd0, (gap >= POLL_TICKS && gap <= POLL_TICKS + 80)}, 1);
    end
    check("ram_reg", {16'd0, wlog[wlog.size()-2].bytes[31:16]}, 32'h0400);
    check("clr_len", wlog[wlog.size()-1].len, 4);
    check("clr_bytes", wlog[wlog.size()-1].bytes, 32'h80000101);
    check("f1_subpage", {31'd0, subpage}, 1);
    check("f1_error", {31'd0, error}, 0);

    // nack on RAM byte 500, then retry
    status_q = '{8'h08, 8'h08}; stat_hi = 8'h00; fault_byte = 500; pb = pix_cnt;
    k = 0;
    while (!error && k < 10000) begin @(negedge clk); k++; end
    check("nack_error", {31'd0, error}, 1);
    check("nack_enable", {31'd0, enable_transfer}, 0);
    t_err = cyc;
    fault_byte = -1;
    repeat (5) @(negedge clk);
    check("nack_pix", pix_cnt - pb, 500);
    check("nack_sb", exp_q.size(), 0);
    lg = poll_count(); fr_seen = 0; k = 0;
    while (poll_count() == lg && k < 30000) begin
      @(negedge clk); k++;
      if (frame_ready) fr_seen++;
    end
    check("retry_seen", {31'd0, (poll_count() > lg)}, 1);
    gap = last_poll_t() - t_err;
    check("retry_gap_ok", {31'd0, (gap >= RETRY_TICKS && gap <= RETRY_TICKS + 5)}, 1);
    check("nack_no_frame", fr_seen, 0);
    check("err_sticky", {31'd0, error}, 1);
    wait_frame(10000);
    check("retry_pix", pix_cnt - pb, 500 + RAM_BYTES);
    check("retry_error", {31'd0, error}, 0);
    check("retry_subpage", {31'd0, subpage}, 0);

    // async reset in the middle of the RAM read
    status_q = '{8'h09, 8'h09}; stat_hi = 8'h01; pb = pix_cnt;
    wait_pix(pb, 300, 10000);
    #3 not_reset = 1'b0;
    #1;
    check("ar_enable", {31'd0, enable_transfer}, 0);
    check("ar_busy", {31'd0, busy}, 0);
    check("ar_rw", {31'd0, read_write}, 0);
    check("ar_paddr", {21'd0, pixel_addr}, 0);
    check("ar_tx", {24'd0, transmit_data}, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    lg = wlog.size(); pb = pix_cnt;
    not_reset = 1'b1;
    k = 0;
    while (wlog.size() == lg && k < 200) begin @(negedge clk); k++; end
    check("ar_restart", {31'd0, (wlog.size() > lg)}, 1);
    if (wlog.size() > lg) check("ar_poll_reg", {16'd0, wlog[lg].bytes[31:16]}, 32'h8000);
    wait_frame(15000);
    check("ar_pix", pix_cnt - pb, RAM_BYTES);
    check("ar_subpage", {31'd0, subpage}, 1);

    // run dropped mid-frame: frame completes, then idle
    status_q = '{8'h08}; stat_hi = 8'h00; pb = pix_cnt;
    wait_pix(pb, 200, 10000);
    run = 1'b0;
    wait_frame(10000);
    check("rd_pix", pix_cnt - pb, RAM_BYTES);
    check("rd_subpage", {31'd0, subpage}, 0);
    lg = poll_count();
    repeat (POLL_TICKS + 50) @(negedge clk);
    check("rd_busy", {31'd0, busy}, 0);
    check("rd_no_poll", poll_count(), lg);
    check("rd_sb", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
